// File: rtl/shake128_absorb_if.sv
// Message stream, permutation handshake and squeeze hand-off for the SHAKE128 absorb controller.
`timescale 1ns/1ps
interface shake128_absorb_if;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [3:0]    in_bytes;
  logic          in_last;
  logic [1599:0] perm_in;
  logic          perm_enable;
  logic          perm_rst;
  logic          perm_valid;
  logic [1599:0] perm_state;
  logic [1599:0] state_out;
  logic          state_valid;
  logic          out_ready;

  modport master (
    output in_valid, in_data, in_bytes, in_last, perm_valid, perm_state, out_ready,
    input  in_ready, perm_in, perm_enable, perm_rst, state_out, state_valid
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, perm_valid, perm_state, out_ready,
    output in_ready, perm_in, perm_enable, perm_rst, state_out, state_valid
  );
endinterface

// File: rtl/shake128_absorb.sv
// SHAKE128 sponge absorb: packs byte-granular words into 168-byte blocks, pads, XORs into the
// chaining state and sequences one external Keccak-f[1600] run per block.
`timescale 1ns/1ps
module shake128_absorb #(
  parameter int unsigned RATE_LANES = 21
) (
  input logic             clk,
  input logic             rst_n,
  shake128_absorb_if.slave bus
);
  localparam int unsigned RateBits  = 64 * RATE_LANES;
  localparam int unsigned CapBits   = 1600 - RateBits;
  localparam logic [7:0]  RateBytes = 8'(8 * RATE_LANES);
  localparam logic [4:0]  LastLane  = 5'(RATE_LANES - 1);
  localparam logic [RateBits-1:0] PadBlk = {8'h80, {(RateBits - 16){1'b0}}, 8'h1F};

  typedef enum logic [2:0] {StIdle, StAbsorb, StPermRst, StPermRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [1599:0]       s_q, s_d;
  logic [1599:0]       perm_in_q, perm_in_d;
  logic [RateBits-1:0] b_q, b_d;
  logic [4:0]          l_q, l_d;
  logic                last_blk_q, last_blk_d;
  logic                pad_pending_q, pad_pending_d;

  logic [63:0]         lane_word;
  logic [RateBits-1:0] blk_next;
  logic [7:0]          pad_pos;
  logic                pad_here;

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    perm_in_d     = perm_in_q;
    b_d           = b_q;
    l_d           = l_q;
    last_blk_d    = last_blk_q;
    pad_pending_d = pad_pending_q;

    for (int k = 0; k < 8; k++) begin
      lane_word[8*k +: 8] = (4'(k) < bus.in_bytes) ? bus.in_data[8*k +: 8] : 8'h00;
    end
    pad_pos  = {l_q, 3'b000} + {4'b0000, bus.in_bytes};
    pad_here = bus.in_last && (pad_pos < RateBytes);
    blk_next = b_q;
    blk_next[{l_q, 6'd0} +: 64] = lane_word;
    // p == 168 leaves this block unpadded; the padding goes into an extra block
    if (pad_here) begin
      blk_next[{pad_pos, 3'd0} +: 8] = blk_next[{pad_pos, 3'd0} +: 8] ^ 8'h1F;
      blk_next[RateBits-1 -: 8]      = blk_next[RateBits-1 -: 8] ^ 8'h80;
    end

    unique case (state_q)
      StIdle: begin
        s_d           = '0;
        b_d           = '0;
        l_d           = '0;
        last_blk_d    = 1'b0;
        pad_pending_d = 1'b0;
        state_d       = StAbsorb;
      end
      StAbsorb: begin
        if (bus.in_valid) begin
          if (bus.in_last || (l_q == LastLane)) begin
            perm_in_d     = s_q ^ {{CapBits{1'b0}}, blk_next};
            b_d           = '0;
            l_d           = '0;
            last_blk_d    = pad_here;
            pad_pending_d = bus.in_last && !pad_here;
            state_d       = StPermRst;
          end else begin
            b_d = blk_next;
            l_d = l_q + 5'd1;
          end
        end
      end
      StPermRst: state_d = StPermRun;
      StPermRun: begin
        if (bus.perm_valid) begin
          s_d = bus.perm_state;
          if (last_blk_q) begin
            state_d = StDone;
          end else if (pad_pending_q) begin
            perm_in_d     = bus.perm_state ^ {{CapBits{1'b0}}, PadBlk};
            last_blk_d    = 1'b1;
            pad_pending_d = 1'b0;
            state_d       = StPermRst;
          end else begin
            state_d = StAbsorb;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          s_d           = '0;
          b_d           = '0;
          l_d           = '0;
          last_blk_d    = 1'b0;
          pad_pending_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      s_q           <= '0;
      perm_in_q     <= '0;
      b_q           <= '0;
      l_q           <= '0;
      last_blk_q    <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      perm_in_q     <= perm_in_d;
      b_q           <= b_d;
      l_q           <= l_d;
      last_blk_q    <= last_blk_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  assign bus.in_ready    = (state_q == StAbsorb);
  assign bus.perm_in     = perm_in_q;
  assign bus.perm_enable = (state_q == StPermRun);
  // Hold the permutation in restart for as long as we are in reset
  assign bus.perm_rst    = (state_q == StPermRst) || !rst_n;
  assign bus.state_out   = s_q;
  assign bus.state_valid = (state_q == StDone);
endmodule
